// File: rtl/role_ctrl.sv
// role_ctrl: AXI4-Lite register front end that sequences, times and reports runs of the role core
// Ports: clk/rst_n (async active-low); s_axil_* AXI4-Lite slave; role_start/role_abort one-cycle
// pulses to the core; role_done completion pulse in; role_arg0/1 run arguments; role_status
// passthrough status word; irq level interrupt.
module role_ctrl #(
  parameter int          ADDR_W  = 6,
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic              role_start,
  output logic              role_abort,
  input  logic              role_done,
  output logic [31:0]       role_arg0,
  output logic [31:0]       role_arg1,
  input  logic [31:0]       role_status,
  output logic              irq
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;
  state_t      r_state, w_next;
  logic        r_init, r_bvalid, r_rvalid, r_irq_en, r_done, r_timeout, r_irq, r_abort;
  logic [31:0] r_rdata, r_arg0, r_arg1, r_tlimit, r_cycles, w_cyc_nxt, w_rd;
  logic [2:0]  w_widx;
  logic        w_wok, w_ctrl_wr, w_stat_wr, w_start_wr, w_abort_wr, w_go, w_to, w_busy;
  logic        w_set_done, w_set_to, w_do_abort, w_unused;
  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = old;
    for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
    return v;
  endfunction
  // r_init keeps every ready low until the first clock after reset release
  assign s_axil_awready = r_init & s_axil_awvalid & s_axil_wvalid & ~r_bvalid;
  assign s_axil_wready  = s_axil_awready;
  assign s_axil_arready = r_init & ~r_rvalid;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_bresp   = 2'b00;
  assign s_axil_rresp   = 2'b00;
  assign role_start     = r_state == S_START;
  assign role_abort     = r_abort;
  assign role_arg0      = r_arg0;
  assign role_arg1      = r_arg1;
  assign irq            = r_irq;
  assign w_unused       = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};
  assign w_busy     = r_state != S_IDLE;
  assign w_widx     = s_axil_awaddr[4:2];
  assign w_wok      = s_axil_awready && s_axil_awaddr[ADDR_W-1:5] == '0;
  assign w_ctrl_wr  = w_wok && w_widx == 3'd0 && s_axil_wstrb[0];
  assign w_stat_wr  = w_wok && w_widx == 3'd1 && s_axil_wstrb[0];
  assign w_start_wr = w_ctrl_wr & s_axil_wdata[0];
  assign w_abort_wr = w_ctrl_wr & s_axil_wdata[1];
  assign w_go       = r_state == S_IDLE && w_start_wr;
  assign w_cyc_nxt  = &r_cycles ? r_cycles : r_cycles + 32'd1;
  // compare against the post-increment count so CYCLES ends exactly at TLIMIT
  assign w_to       = r_tlimit != '0 && w_cyc_nxt == r_tlimit;
  always_comb begin
    w_next     = r_state;
    w_set_done = 1'b0;
    w_set_to   = 1'b0;
    w_do_abort = 1'b0;
    unique case (r_state)
      S_IDLE:  if (w_start_wr) w_next = S_START;
      S_START: w_next = S_RUN;
      S_RUN: begin
        if (role_done) begin
          w_next     = S_IDLE;
          w_set_done = 1'b1;
        end else if (w_to) begin
          w_next     = S_IDLE;
          w_set_to   = 1'b1;
          w_do_abort = 1'b1;
        end else if (w_abort_wr) begin
          w_next     = S_IDLE;
          w_do_abort = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    w_rd = '0;
    if (s_axil_araddr[ADDR_W-1:5] == '0)
      case (s_axil_araddr[4:2])
        3'd0:    w_rd = {29'd0, r_irq_en, 2'b00};
        3'd1:    w_rd = {29'd0, r_timeout, r_done, w_busy};
        3'd2:    w_rd = r_arg0;
        3'd3:    w_rd = r_arg1;
        3'd4:    w_rd = r_tlimit;
        3'd5:    w_rd = r_cycles;
        3'd6:    w_rd = role_status;
        default: w_rd = VERSION;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init    <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_irq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_irq     <= 1'b0;
      r_abort   <= 1'b0;
      r_arg0    <= '0;
      r_arg1    <= '0;
      r_tlimit  <= '0;
      r_cycles  <= '0;
    end else begin
      r_init    <= 1'b1;
      r_bvalid  <= s_axil_awready ? 1'b1 : (s_axil_bready ? 1'b0 : r_bvalid);
      r_rvalid  <= s_axil_arready && s_axil_arvalid ? 1'b1 : (s_axil_rready ? 1'b0 : r_rvalid);
      if (s_axil_arready && s_axil_arvalid) r_rdata <= w_rd;
      if (w_ctrl_wr) r_irq_en <= s_axil_wdata[2];
      // a flag being set this cycle beats a simultaneous W1C
      r_done    <= w_set_done | (r_done & ~(w_stat_wr & s_axil_wdata[1]) & ~w_go);
      r_timeout <= w_set_to | (r_timeout & ~(w_stat_wr & s_axil_wdata[2]) & ~w_go);
      r_irq     <= r_irq_en & (r_done | r_timeout);
      r_abort   <= w_do_abort;
      if (w_go) r_cycles <= '0;
      else if (r_state == S_RUN) r_cycles <= w_cyc_nxt;
      if (w_wok && !w_busy && w_widx == 3'd2) r_arg0 <= f_merge(r_arg0, s_axil_wdata, s_axil_wstrb);
      if (w_wok && !w_busy && w_widx == 3'd3) r_arg1 <= f_merge(r_arg1, s_axil_wdata, s_axil_wstrb);
      if (w_wok && w_widx == 3'd4) r_tlimit <= f_merge(r_tlimit, s_axil_wdata, s_axil_wstrb);
    end
  end
endmodule

// File: tb/tb_role_ctrl.sv
// tb_role_ctrl: directed stimulus for role_ctrl checked against a run-age model every cycle plus literal register reads
module tb_role_ctrl;
  localparam logic [31:0] VER = 32'h0001_0000;
  logic        clk, rst_n;
  logic [5:0]  s_axil_awaddr, s_axil_araddr;
  logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [31:0] s_axil_wdata, s_axil_rdata;
  logic [3:0]  s_axil_wstrb;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready, s_axil_rvalid, s_axil_rready;
  logic        role_start, role_abort, role_done, irq;
  logic [31:0] role_arg0, role_arg1, role_status;
  int total = 0, bad = 0, cyc = 0, n_start = 0, n_abort = 0, t_start = 0;
  role_ctrl #(.ADDR_W(6), .VERSION(VER)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .role_start(role_start), .role_abort(role_abort), .role_done(role_done),
    .role_arg0(role_arg0), .role_arg1(role_arg1), .role_status(role_status), .irq(irq)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = old;
    for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
    return v;
  endfunction
  // model: m_age counts cycles since an accepted START (0 = idle, 1 = start pulse, >=2 = running)
  logic        m_init, m_bvalid, m_rvalid, m_irq_en, m_done, m_to, m_irq, m_abort;
  logic [31:0] m_arg0, m_arg1, m_tlim, m_cyc, mw_c;
  int          m_age;
  logic [3:0]  mw_idx;
  logic        mw_acc, mw_st, mw_ab, mw_cd, mw_ct, mw_ctrl, mw_stat;
  assign mw_acc  = m_init && s_axil_awvalid && s_axil_wvalid && !m_bvalid;
  assign mw_idx  = s_axil_awaddr[5:2];
  assign mw_ctrl = mw_acc && mw_idx == 4'd0 && s_axil_wstrb[0];
  assign mw_stat = mw_acc && mw_idx == 4'd1 && s_axil_wstrb[0];
  assign mw_st   = mw_ctrl && s_axil_wdata[0];
  assign mw_ab   = mw_ctrl && s_axil_wdata[1];
  assign mw_cd   = mw_stat && s_axil_wdata[1];
  assign mw_ct   = mw_stat && s_axil_wdata[2];
  assign mw_c    = (m_cyc == 32'hFFFF_FFFF) ? m_cyc : m_cyc + 32'd1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_init <= 0; m_bvalid <= 0; m_rvalid <= 0; m_irq_en <= 0; m_done <= 0; m_to <= 0;
      m_irq <= 0; m_abort <= 0; m_arg0 <= 0; m_arg1 <= 0; m_tlim <= 0; m_cyc <= 0; m_age <= 0;
    end else begin
      m_init   <= 1;
      m_bvalid <= mw_acc ? 1'b1 : (s_axil_bready ? 1'b0 : m_bvalid);
      m_rvalid <= (m_init && s_axil_arvalid && !m_rvalid) ? 1'b1 : (s_axil_rready ? 1'b0 : m_rvalid);
      if (mw_ctrl) m_irq_en <= s_axil_wdata[2];
      if (mw_acc && mw_idx == 4'd2 && m_age == 0) m_arg0 <= merge(m_arg0, s_axil_wdata, s_axil_wstrb);
      if (mw_acc && mw_idx == 4'd3 && m_age == 0) m_arg1 <= merge(m_arg1, s_axil_wdata, s_axil_wstrb);
      if (mw_acc && mw_idx == 4'd4) m_tlim <= merge(m_tlim, s_axil_wdata, s_axil_wstrb);
      m_irq   <= m_irq_en && (m_done || m_to);
      m_abort <= 0;
      if (mw_cd) m_done <= 0;
      if (mw_ct) m_to <= 0;
      if (mw_st && m_age == 0) begin
        m_age <= 1; m_cyc <= 0; m_done <= 0; m_to <= 0;
      end else if (m_age == 1) m_age <= 2;
      else if (m_age >= 2) begin
        m_cyc <= mw_c;
        if (role_done) begin m_age <= 0; m_done <= 1; end
        else if (m_tlim != 0 && mw_c == m_tlim) begin m_age <= 0; m_to <= 1; m_abort <= 1; end
        else if (mw_ab) begin m_age <= 0; m_abort <= 1; end
        else m_age <= m_age + 1;
      end
    end
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (role_start) begin n_start <= n_start + 1; t_start <= cyc; end
    if (role_abort) n_abort <= n_abort + 1;
  end
  always @(negedge clk) begin
    chk("role_start", 32'(role_start), 32'(m_age == 1));
    chk("role_abort", 32'(role_abort), 32'(m_abort));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("role_arg0", role_arg0, m_arg0);
    chk("role_arg1", role_arg1, m_arg1);
    chk("bvalid", 32'(s_axil_bvalid), 32'(m_bvalid));
    chk("rvalid", 32'(s_axil_rvalid), 32'(m_rvalid));
    chk("awready", 32'(s_axil_awready), 32'(mw_acc));
    chk("wready", 32'(s_axil_wready), 32'(mw_acc));
    chk("arready", 32'(s_axil_arready), 32'(m_init && !m_rvalid));
    chk("resp", 32'({s_axil_bresp, s_axil_rresp}), 32'd0);
  end
  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int k;
    @(posedge clk); #1;
    s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s; s_axil_awvalid = 1; s_axil_wvalid = 1;
    k = 0;
    @(negedge clk);
    while (!s_axil_awready && k < 20) begin @(negedge clk); k++; end
    chk("wr_accept", 32'(s_axil_awready), 32'd1);
    @(posedge clk); #1;
    s_axil_awvalid = 0; s_axil_wvalid = 0;
    k = 0;
    @(negedge clk);
    while (!s_axil_bvalid && k < 20) begin @(negedge clk); k++; end
    chk("wr_bvalid", 32'(s_axil_bvalid), 32'd1);
  endtask
  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string nm);
    int k;
    @(posedge clk); #1;
    s_axil_araddr = a; s_axil_arvalid = 1;
    k = 0;
    @(negedge clk);
    while (!s_axil_arready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    s_axil_arvalid = 0;
    k = 0;
    @(negedge clk);
    while (!s_axil_rvalid && k < 20) begin @(negedge clk); k++; end
    chk(nm, s_axil_rdata, exp);
  endtask
  // drive role_done during the n-th RUN cycle after the last role_start pulse
  task automatic done_at(input int n);
    int k;
    k = 0;
    @(negedge clk);
    while (cyc < t_start + n - 1 && k < 200) begin @(negedge clk); k++; end
    @(posedge clk); #1 role_done = 1;
    @(posedge clk); #1 role_done = 0;
  endtask
  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ready"}, 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 32'd0);
    chk({nm, "_valid"}, 32'({s_axil_bvalid, s_axil_rvalid}), 32'd0);
    chk({nm, "_rdata"}, s_axil_rdata, 32'd0);
    chk({nm, "_pulses"}, 32'({role_start, role_abort, irq}), 32'd0);
    chk({nm, "_args"}, role_arg0 | role_arg1, 32'd0);
  endtask
  initial begin
    int s0, s1, k;
    rst_n = 1; role_done = 0; role_status = 32'h1234_5678;
    s_axil_awaddr = 0; s_axil_awvalid = 0; s_axil_wdata = 0; s_axil_wstrb = 0; s_axil_wvalid = 0;
    s_axil_bready = 1; s_axil_araddr = 0; s_axil_arvalid = 0; s_axil_rready = 1;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1;
    rd(6'h04, 32'h0, "status_after_reset");
    rd(6'h00, 32'h0, "ctrl_after_reset");
    // normal run: done 10 cycles after start
    wr(6'h08, 32'hA5A5_0001, 4'hF);
    wr(6'h0C, 32'hCAFE_BABE, 4'b0101);
    rd(6'h0C, 32'h00FE_00BE, "arg1_wstrb");
    wr(6'h00, 32'h4, 4'h1);
    s0 = n_start;
    wr(6'h00, 32'h5, 4'h1);
    done_at(10);
    repeat (4) @(negedge clk);
    chk("start_pulses", 32'(n_start - s0), 32'd1);
    chk("irq_after_done", 32'(irq), 32'd1);
    rd(6'h14, 32'd10, "cycles_done");
    rd(6'h04, 32'h2, "status_done");
    rd(6'h00, 32'h4, "ctrl_irq_en");
    wr(6'h04, 32'h2, 4'hF);
    repeat (3) @(negedge clk);
    chk("irq_after_w1c", 32'(irq), 32'd0);
    // timeout
    wr(6'h10, 32'd5, 4'hF);
    s1 = n_abort;
    wr(6'h00, 32'h5, 4'h1);
    repeat (15) @(negedge clk);
    chk("timeout_aborts", 32'(n_abort - s1), 32'd1);
    rd(6'h04, 32'h4, "status_timeout");
    rd(6'h14, 32'd5, "cycles_timeout");
    // done and timeout in the same cycle
    wr(6'h10, 32'd4, 4'hF);
    s1 = n_abort;
    wr(6'h00, 32'h5, 4'h1);
    done_at(4);
    repeat (5) @(negedge clk);
    chk("done_beats_timeout_abort", 32'(n_abort - s1), 32'd0);
    rd(6'h04, 32'h2, "status_done_vs_timeout");
    rd(6'h14, 32'd4, "cycles_done_vs_timeout");
    // writes while busy, then abort
    wr(6'h10, 32'd0, 4'hF);
    s0 = n_start;
    wr(6'h00, 32'h5, 4'h1);
    wr(6'h00, 32'h5, 4'h1);
    wr(6'h08, 32'hDEAD_BEEF, 4'hF);
    chk("arg0_held", role_arg0, 32'hA5A5_0001);
    rd(6'h04, 32'h1, "status_busy");
    s1 = n_abort;
    wr(6'h00, 32'h6, 4'h1);
    repeat (3) @(negedge clk);
    chk("busy_start_pulses", 32'(n_start - s0), 32'd1);
    chk("abort_pulses", 32'(n_abort - s1), 32'd1);
    rd(6'h04, 32'h0, "status_abort");
    rd(6'h08, 32'hA5A5_0001, "arg0_read");
    // write response back-pressure
    @(posedge clk); #1;
    s_axil_bready = 0; s_axil_awaddr = 6'h10; s_axil_wdata = 32'h77; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1; s_axil_wvalid = 1;
    k = 0;
    @(negedge clk);
    while (!s_axil_awready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk); #1 s_axil_awaddr = 6'h3C; s_axil_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_bvalid", 32'(s_axil_bvalid), 32'd1);
      chk("hold_awready", 32'(s_axil_awready), 32'd0);
    end
    @(posedge clk); #1 s_axil_bready = 1;
    k = 0;
    @(negedge clk);
    while (!s_axil_awready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk); #1 s_axil_awvalid = 0; s_axil_wvalid = 0;
    repeat (3) @(negedge clk);
    rd(6'h10, 32'h77, "tlimit_after_hold");
    // read data back-pressure
    @(posedge clk); #1 s_axil_rready = 0; s_axil_araddr = 6'h1C; s_axil_arvalid = 1;
    k = 0;
    @(negedge clk);
    while (!s_axil_arready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk); #1 s_axil_araddr = 6'h3C;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rvalid", 32'(s_axil_rvalid), 32'd1);
      chk("hold_version", s_axil_rdata, VER);
      chk("hold_arready", 32'(s_axil_arready), 32'd0);
    end
    @(posedge clk); #1 s_axil_rready = 1;
    k = 0;
    @(negedge clk);
    while (!s_axil_arready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk); #1 s_axil_arvalid = 0;
    k = 0;
    @(negedge clk);
    while (!s_axil_rvalid && k < 20) begin @(negedge clk); k++; end
    chk("unmapped_read", s_axil_rdata, 32'd0);
    rd(6'h18, 32'h1234_5678, "role_status");
    // reset in the middle of a run
    wr(6'h00, 32'h5, 4'h1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("midrun_reset");
    @(posedge clk); #1 rst_n = 1;
    rd(6'h04, 32'h0, "status_midrun_reset");
    rd(6'h08, 32'h0, "arg0_midrun_reset");
    rd(6'h10, 32'h0, "tlimit_midrun_reset");
    rd(6'h14, 32'h0, "cycles_midrun_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
